rle_bbox_tracker: RTL and testbench
===================================

RLE_BBOX_TRACKER -- requirements
Module: rle_bbox_tracker

Interface
REQ-001 SHALL have parameter IMAGE_W, default 640: pixels per line.
REQ-002 SHALL have parameter IMAGE_H, default 480: lines per frame.
REQ-003 SHALL have parameter MIN_LINES, default 4: minimum valid lines for a detection.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse; restarts accumulation.
REQ-007 SHALL have port line_end  input  1  one-cycle pulse; the per-line run-length result is valid this cycle.
REQ-008 SHALL have port seg_start  input  13  black-run length before the white segment (x of first white pixel).
REQ-009 SHALL have port seg_width  input  13  white segment length; 0 means no segment.
REQ-010 SHALL have ports x_min, x_max, y_min, y_max  output  11 each  bounding box of the last completed frame.
REQ-011 SHALL have port centre_x  output  11  (x_min+x_max)>>1.
REQ-012 SHALL have port found  output  1  result contains a detection.
REQ-013 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-014 SHALL have port overrun  output  1  sticky; an unread result was overwritten.

Function
REQ-015 Line sampled only when line_end=1; seg_start/seg_width ignored otherwise.
REQ-016 Line valid iff seg_width!=0 and seg_start<IMAGE_W.
REQ-017 seg_end = seg_start+seg_width-1, computed at 14 bits and clamped to IMAGE_W-1.
REQ-018 Accumulators: acc_xmin (init IMAGE_W-1), acc_xmax (init 0), acc_ymin (init IMAGE_H-1), acc_ymax (init 0), line count y (11 bits), valid-line count vcnt (11 bits, saturating).
REQ-019 Valid line: acc_xmin=min(acc_xmin,seg_start), acc_xmax=max(acc_xmax,seg_end), acc_ymin=min(acc_ymin,y), acc_ymax=max(acc_ymax,y), vcnt+1.
REQ-020 Every line_end increments y, valid or not.
REQ-021 FSM states: ACCUM, FINISH, ACCUM is entered after reset.
REQ-022 ACCUM->FINISH on the line_end where y==IMAGE_H-1 (that line is accumulated first).
REQ-023 FINISH lasts exactly one cycle: it copies the accumulators to the output registers, computes centre_x, sets found=(vcnt>=MIN_LINES), and asserts out_valid; then it reinitialises the accumulators and sets y=0 and state ACCUM.
REQ-024 found=0: outputs x_min=x_max=y_min=y_max=centre_x=0.
REQ-025 Latency: final line_end at cycle T -> out_valid high at T+2.
REQ-026 Line_end pulses arriving during FINISH SHALL be dropped.
REQ-027 out_valid holds, outputs stable, until a cycle with out_valid=1 and out_ready=1; it clears the next cycle.
REQ-028 FINISH while out_valid=1 and no handshake that cycle: output registers overwritten, out_valid stays 1, overrun set.
REQ-029 Handshake in the same cycle as FINISH: new result loaded, out_valid stays 1, no overrun.
REQ-030 overrun clears only on reset.
REQ-031 frame_start in ACCUM: reinitialise accumulators and y=0, with no output. It overrides a coincident line_end.
REQ-032 frame_start in FINISH: the FINISH completes normally; accumulators are reinitialised anyway.
REQ-033 y reaching IMAGE_H without frame_start never happens because FINISH resets y; y SHALL NOT wrap otherwise.

Reset
REQ-034 reset_n=0 asynchronously forces: state ACCUM; accumulators to their init values; y=0, vcnt=0; outputs x_min/x_max/y_min/y_max/centre_x=0; found=0, out_valid=0, overrun=0.
REQ-035 Reset mid-frame discards the partial frame; the first line_end after release is line y=0.

Verification
REQ-036 IMAGE_H=8, MIN_LINES=2. Lines 2..5 have seg_start=100, seg_width=50; other lines have width 0. Response: x_min=100, x_max=149, y_min=2, y_max=5, centre_x=124, found=1, out_valid at T+2.
REQ-037 All lines have seg_start=639, seg_width=0. Response: found=0, all coordinates 0, out_valid=1.
REQ-038 seg_start=600, seg_width=100. Response: x_max clamped to 639.
REQ-039 Two frames complete with out_ready=0. Response: second result visible, overrun=1. With out_ready=1 one cycle: out_valid=0 next cycle.
REQ-040 frame_start coincident with line_end at line 3. Response: the line is ignored, y=0, and there is no out_valid.
REQ-041 reset_n low mid-frame at line 4, then a full frame. Response: outputs 0 during reset; the result reflects only the post-reset frame.

Source files
------------

// File: rtl/rle_bbox_tracker.sv
// Bounding-box tracker fed by a per-line run-length segmenter.
// Each line_end presents one white segment (start, width). Valid segments
// grow a frame-wide box; on the last line the box is published through a
// valid/ready result register with a sticky overrun flag.
module rle_bbox_tracker #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int MIN_LINES = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic [12:0] seg_start,
  input  logic [12:0] seg_width,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [10:0] centre_x,
  output logic        found,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [10:0] X_LAST   = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST   = 11'(IMAGE_H - 1);
  localparam logic [13:0] W_14     = 14'(IMAGE_W);
  localparam logic [13:0] X_LAST14 = 14'(IMAGE_W - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_LINES);

  typedef enum logic {ACCUM, FINISH} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [10:0] r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
  logic [10:0] r_y, r_vcnt;

  logic [10:0] r_x_min, r_x_max, r_y_min, r_y_max, r_centre_x;
  logic        r_found, r_out_valid, r_overrun;

  logic        w_take;
  logic        w_finish;
  logic        w_line_valid;
  logic [13:0] w_seg_end14;
  logic [10:0] w_seg_end;
  logic        w_found;
  logic [11:0] w_csum;
  logic [10:0] w_centre;

  // A line is taken only in ACCUM; frame_start wins over a coincident line_end.
  assign w_take       = line_end && !frame_start && (r_state == ACCUM);
  assign w_finish     = (r_state == FINISH);
  assign w_line_valid = (seg_width != 13'd0) && ({1'b0, seg_start} < W_14);
  // 14-bit end so start+width cannot overflow before the clamp.
  assign w_seg_end14  = {1'b0, seg_start} + {1'b0, seg_width} - 14'd1;
  assign w_seg_end    = (w_seg_end14 > X_LAST14) ? X_LAST : w_seg_end14[10:0];

  assign w_found  = (r_vcnt >= MIN_CNT);
  assign w_csum   = {1'b0, r_acc_xmin} + {1'b0, r_acc_xmax};
  assign w_centre = 11'(w_csum >> 1);

  // State register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) r_state <= ACCUM;
    else          r_state <= w_state_next;
  end

  // Next state: the last line of the frame moves to a single FINISH cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_take && (r_y == Y_LAST)) w_state_next = FINISH;
      FINISH:  w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  // Frame accumulators: restart on FINISH or frame_start, grow on each taken line.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_xmin <= X_LAST;
      r_acc_xmax <= '0;
      r_acc_ymin <= Y_LAST;
      r_acc_ymax <= '0;
      r_y        <= '0;
      r_vcnt     <= '0;
    end else if (w_finish || frame_start) begin
      r_acc_xmin <= X_LAST;
      r_acc_xmax <= '0;
      r_acc_ymin <= Y_LAST;
      r_acc_ymax <= '0;
      r_y        <= '0;
      r_vcnt     <= '0;
    end else if (w_take) begin
      if (w_line_valid) begin
        if (seg_start[10:0] < r_acc_xmin) r_acc_xmin <= seg_start[10:0];
        if (w_seg_end > r_acc_xmax)       r_acc_xmax <= w_seg_end;
        if (r_y < r_acc_ymin)             r_acc_ymin <= r_y;
        if (r_y > r_acc_ymax)             r_acc_ymax <= r_y;
        if (r_vcnt != 11'h7FF)            r_vcnt     <= r_vcnt + 11'd1;
      end
      if (r_y != 11'h7FF) r_y <= r_y + 11'd1;
    end
  end

  // Result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_x_min     <= '0;
      r_x_max     <= '0;
      r_y_min     <= '0;
      r_y_max     <= '0;
      r_centre_x  <= '0;
      r_found     <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_finish) begin
      r_x_min     <= w_found ? r_acc_xmin : 11'd0;
      r_x_max     <= w_found ? r_acc_xmax : 11'd0;
      r_y_min     <= w_found ? r_acc_ymin : 11'd0;
      r_y_max     <= w_found ? r_acc_ymax : 11'd0;
      r_centre_x  <= w_found ? w_centre   : 11'd0;
      r_found     <= w_found;
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) r_overrun <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign x_min     = r_x_min;
  assign x_max     = r_x_max;
  assign y_min     = r_y_min;
  assign y_max     = r_y_max;
  assign centre_x  = r_centre_x;
  assign found     = r_found;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_rle_bbox_tracker.sv
// Directed bench for rle_bbox_tracker with an 8-line frame and MIN_LINES=2.
module tb_rle_bbox_tracker;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        line_end;
  logic [12:0] seg_start;
  logic [12:0] seg_width;
  logic [10:0] x_min, x_max, y_min, y_max, centre_x;
  logic        found, out_valid, out_ready, overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [57:0] got;
  assign got = {x_min, x_max, y_min, y_max, centre_x, found, out_valid, overrun};

  rle_bbox_tracker #(.IMAGE_W(640), .IMAGE_H(8), .MIN_LINES(2)) dut (
    .CLK(CLK), .reset_n(reset_n), .frame_start(frame_start), .line_end(line_end),
    .seg_start(seg_start), .seg_width(seg_width),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .centre_x(centre_x), .found(found), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic [57:0] exp_of(input int xmn, input int xmx, input int ymn,
                                         input int ymx, input int cx, input bit f,
                                         input bit v, input bit o);
    return {11'(xmn), 11'(xmx), 11'(ymn), 11'(ymx), 11'(cx), f, v, o};
  endfunction

  // One line_end pulse spanning exactly one rising edge; returns at the next falling edge.
  task automatic send_line(input int s, input int w);
    line_end  = 1'b1;
    seg_start = 13'(s);
    seg_width = 13'(w);
    @(negedge CLK);
    line_end  = 1'b0;
    seg_start = 13'd0;
    seg_width = 13'd0;
  endtask

  // n lines indexed 0..n-1; lines vfirst..vlast carry (s,w), the rest are empty.
  task automatic run_lines(input int n, input int vfirst, input int vlast,
                           input int s, input int w);
    for (int i = 0; i < n; i++) begin
      if (i >= vfirst && i <= vlast) send_line(s, w);
      else                           send_line(639, 0);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_start = 1'b0; line_end = 1'b0;
    seg_start = 13'd0; seg_width = 13'd0; out_ready = 1'b0;
    #1;
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL reset_state: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 0, 0));
    end
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    $display("reset: outputs %h", got);
  endtask

  task automatic test_basic_frame();
    run_lines(8, 2, 5, 100, 50);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_latency_t1: out_valid %b want 0", out_valid);
    end
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(100, 149, 2, 5, 124, 1, 1, 0)) begin
      n_err++; $display("FAIL basic_frame: got %h want %h", got, exp_of(100, 149, 2, 5, 124, 1, 1, 0));
    end
    $display("basic frame: x %0d..%0d y %0d..%0d cx %0d found %b", x_min, x_max, y_min, y_max, centre_x, found);
  endtask

  // Clamped segment end, and a handshake landing in the FINISH cycle (no overrun).
  task automatic test_clamp_with_handshake();
    run_lines(8, 3, 4, 600, 100);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    n_vec++;
    if (got !== exp_of(600, 639, 3, 4, 619, 1, 1, 0)) begin
      n_err++; $display("FAIL clamp_handshake: got %h want %h", got, exp_of(600, 639, 3, 4, 619, 1, 1, 0));
    end
    handshake();
    n_vec++;
    if (got !== exp_of(600, 639, 3, 4, 619, 1, 0, 0)) begin
      n_err++; $display("FAIL clamp_release: got %h want %h", got, exp_of(600, 639, 3, 4, 619, 1, 0, 0));
    end
    $display("clamp frame: x_max %0d out_valid %b overrun %b", x_max, out_valid, overrun);
  endtask

  task automatic test_no_segment();
    run_lines(8, 99, 99, 0, 0);
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 1, 0)) begin
      n_err++; $display("FAIL no_segment: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 1, 0));
    end
    handshake();
    $display("empty frame: found %b coords %0d,%0d,%0d,%0d", found, x_min, x_max, y_min, y_max);
  endtask

  // A line_end in the FINISH cycle must not count as line 0 of the next frame.
  task automatic test_finish_drop();
    run_lines(8, 99, 99, 0, 0);
    send_line(100, 50);
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 1, 0)) begin
      n_err++; $display("FAIL drop_first_result: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 1, 0));
    end
    handshake();
    run_lines(7, 0, 6, 100, 50);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL drop_early_finish: out_valid %b want 0", out_valid);
    end
    run_lines(1, 0, 0, 100, 50);
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(100, 149, 0, 7, 124, 1, 1, 0)) begin
      n_err++; $display("FAIL drop_frame: got %h want %h", got, exp_of(100, 149, 0, 7, 124, 1, 1, 0));
    end
    handshake();
    $display("finish drop: y %0d..%0d", y_min, y_max);
  endtask

  task automatic test_frame_start();
    run_lines(3, 0, 2, 20, 10);
    frame_start = 1'b1;
    send_line(20, 10);
    frame_start = 1'b0;
    run_lines(7, 99, 99, 0, 0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL frame_start_no_output: out_valid %b want 0", out_valid);
    end
    run_lines(1, 99, 99, 0, 0);
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 1, 0)) begin
      n_err++; $display("FAIL frame_start_result: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 1, 0));
    end
    handshake();
    $display("frame_start abort: found %b", found);
  endtask

  task automatic test_back_to_back();
    run_lines(8, 2, 5, 10, 20);
    @(negedge CLK);
    run_lines(8, 1, 3, 200, 10);
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(200, 209, 1, 3, 204, 1, 1, 1)) begin
      n_err++; $display("FAIL overrun_result: got %h want %h", got, exp_of(200, 209, 1, 3, 204, 1, 1, 1));
    end
    handshake();
    n_vec++;
    if (got !== exp_of(200, 209, 1, 3, 204, 1, 0, 1)) begin
      n_err++; $display("FAIL overrun_release: got %h want %h", got, exp_of(200, 209, 1, 3, 204, 1, 0, 1));
    end
    $display("back to back: x %0d..%0d overrun %b", x_min, x_max, overrun);
  endtask

  task automatic test_reset_midframe();
    run_lines(4, 0, 3, 50, 30);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL midreset_async: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 0, 0));
    end
    repeat (2) @(negedge CLK);
    n_vec++;
    if (got !== exp_of(0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_err++; $display("FAIL midreset_hold: got %h want %h", got, exp_of(0, 0, 0, 0, 0, 0, 0, 0));
    end
    reset_n = 1'b1;
    @(negedge CLK);
    run_lines(8, 6, 7, 300, 40);
    @(negedge CLK);
    n_vec++;
    if (got !== exp_of(300, 339, 6, 7, 319, 1, 1, 0)) begin
      n_err++; $display("FAIL midreset_frame: got %h want %h", got, exp_of(300, 339, 6, 7, 319, 1, 1, 0));
    end
    $display("reset midframe: x %0d..%0d y %0d..%0d", x_min, x_max, y_min, y_max);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clamp_with_handshake();
    test_no_segment();
    test_finish_drop();
    test_frame_start();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
